// File: rtl/instr_cycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_cycle_seq                                              |
// | Description : Machine-cycle sequencer and instruction latch for the 4004   |
// |               core. Produces the eight one-hot phase strobes A1..X3 plus   |
// |               SYNC, latches the OPR/OPA nibbles during M1/M2 and tracks    |
// |               two-word and FIN execution cycles.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   CLK      in   1  core clock, rising edge                                 |
// |   RES      in   1  synchronous active-high reset                           |
// |   DATA_I   in   4  nibble bus from ROM                                     |
// |   STALL    in   1  hold request at X3 (only with FETCH_STALL_EN)           |
// |   A1..A3   out  1  address phase strobes                                   |
// |   M1, M2   out  1  memory phase strobes                                    |
// |   X1..X3   out  1  execute phase strobes                                   |
// |   SYNC     out  1  high during X3                                          |
// |   opropa0  out  8  first instruction word {OPR,OPA}                        |
// |   opropa1  out  8  second word of a two-word instruction                   |
// |   cycle2   out  1  current machine cycle is a second (execution) cycle     |
// |   do_fin   out  1  current machine cycle is the FIN fetch cycle            |
// +----------------------------------------------------------------------------+
// | Configuration macro: FETCH_STALL_EN - adds the STALL port; STALL=1 at X3   |
// | freezes the whole sequencer in X3 until released.                          |
// +----------------------------------------------------------------------------+
module instr_cycle_seq (
  input  logic       CLK,
  input  logic       RES,
  input  logic [3:0] DATA_I,
`ifdef FETCH_STALL_EN
  input  logic       STALL,
`endif
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       M1,
  output logic       M2,
  output logic       X1,
  output logic       X2,
  output logic       X3,
  output logic       SYNC,
  output logic [7:0] opropa0,
  output logic [7:0] opropa1,
  output logic       cycle2,
  output logic       do_fin
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t     phase, phase_nx;
  logic       run, run_nx;
  logic [3:0] opr_stage, opr_stage_nx;
  logic [7:0] opropa0_q, opropa0_nx;
  logic [7:0] opropa1_q, opropa1_nx;
  logic       cycle2_q, cycle2_nx;
  logic       do_fin_q, do_fin_nx;
  logic       pend2, pend2_nx;
  logic       pendfin, pendfin_nx;

  logic       hold;
  logic [7:0] fetch_word;
  logic       is_two_word;
  logic       is_fin;

  // Word being completed on the M2 edge: OPR latched at M1, OPA on the bus now.
  assign fetch_word = {opr_stage, DATA_I};

  // JCN, JUN, JMS, ISZ always take a second word; FIM is 0010 with even OPA.
  assign is_two_word = (fetch_word[7:4] == 4'b0001) ||
                       (fetch_word[7:4] == 4'b0100) ||
                       (fetch_word[7:4] == 4'b0101) ||
                       (fetch_word[7:4] == 4'b0111) ||
                       ((fetch_word[7:4] == 4'b0010) && !fetch_word[0]);
  assign is_fin      = (fetch_word[7:4] == 4'b0011) && !fetch_word[0];

`ifdef FETCH_STALL_EN
  assign hold = run && (phase == PH_X3) && STALL;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RES) begin
      phase     <= PH_A1;
      run       <= 1'b0;
      opr_stage <= 4'h0;
      opropa0_q <= 8'h00;
      opropa1_q <= 8'h00;
      cycle2_q  <= 1'b0;
      do_fin_q  <= 1'b0;
      pend2     <= 1'b0;
      pendfin   <= 1'b0;
    end else begin
      phase     <= phase_nx;
      run       <= run_nx;
      opr_stage <= opr_stage_nx;
      opropa0_q <= opropa0_nx;
      opropa1_q <= opropa1_nx;
      cycle2_q  <= cycle2_nx;
      do_fin_q  <= do_fin_nx;
      pend2     <= pend2_nx;
      pendfin   <= pendfin_nx;
    end
  end

  always_comb begin
    phase_nx     = phase;
    run_nx       = run;
    opr_stage_nx = opr_stage;
    opropa0_nx   = opropa0_q;
    opropa1_nx   = opropa1_q;
    cycle2_nx    = cycle2_q;
    do_fin_nx    = do_fin_q;
    pend2_nx     = pend2;
    pendfin_nx   = pendfin;

    if (!run) begin
      // First edge out of reset only starts the sequencer; A1 is shown next.
      run_nx   = 1'b1;
      phase_nx = PH_A1;
    end else if (!hold) begin
      phase_nx = phase_t'(phase + 3'd1);
      case (phase)
        PH_M1: opr_stage_nx = DATA_I;
        PH_M2: begin
          if (!cycle2_q) begin
            opropa0_nx = fetch_word;
            pend2_nx   = is_two_word;
            pendfin_nx = is_fin;
          end else if (!do_fin_q) begin
            opropa1_nx = fetch_word;
          end
          // During a FIN cycle the fetched byte belongs to the register pair.
        end
        PH_X3: begin
          // Pending flags are only ever set in a first cycle, so a second
          // cycle can never chain into another one.
          if (!cycle2_q) begin
            cycle2_nx = pend2 | pendfin;
            do_fin_nx = pendfin;
          end else begin
            cycle2_nx = 1'b0;
            do_fin_nx = 1'b0;
          end
          pend2_nx   = 1'b0;
          pendfin_nx = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign A1      = run && (phase == PH_A1);
  assign A2      = run && (phase == PH_A2);
  assign A3      = run && (phase == PH_A3);
  assign M1      = run && (phase == PH_M1);
  assign M2      = run && (phase == PH_M2);
  assign X1      = run && (phase == PH_X1);
  assign X2      = run && (phase == PH_X2);
  assign X3      = run && (phase == PH_X3);
  assign SYNC    = X3;
  assign opropa0 = opropa0_q;
  assign opropa1 = opropa1_q;
  assign cycle2  = cycle2_q;
  assign do_fin  = do_fin_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_cycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_cycle_seq                                           |
// | Description : Scoreboard bench for instr_cycle_seq. Stimulus feeds one     |
// |               instruction byte per machine cycle and pushes the expected   |
// |               latch state; a monitor pops and compares at every X1.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_cycle_seq;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic [3:0] DATA_I = 4'h0;
  logic       STALL = 1'b0;
  logic       A1, A2, A3, M1, M2, X1, X2, X3, SYNC;
  logic [7:0] opropa0, opropa1;
  logic       cycle2, do_fin;

  int checks = 0;
  int errors = 0;

  instr_cycle_seq dut (
    .CLK     (CLK),
    .RES     (RES),
    .DATA_I  (DATA_I),
`ifdef FETCH_STALL_EN
    .STALL   (STALL),
`endif
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .M1      (M1),
    .M2      (M2),
    .X1      (X1),
    .X2      (X2),
    .X3      (X3),
    .SYNC    (SYNC),
    .opropa0 (opropa0),
    .opropa1 (opropa1),
    .cycle2  (cycle2),
    .do_fin  (do_fin)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       c2;
    logic       fin;
    logic [7:0] op0;
    logic [7:0] op1;
  } exp_t;

  exp_t exp_q[$];

  // Instruction-level reference state
  logic       m_second = 1'b0;
  logic       m_fin    = 1'b0;
  logic [7:0] m_op0    = 8'h00;
  logic [7:0] m_op1    = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic two_word(input logic [7:0] b);
    return (b[7:4] == 4'h1) || (b[7:4] == 4'h4) || (b[7:4] == 4'h5) ||
           (b[7:4] == 4'h7) || ((b[7:4] == 4'h2) && !b[0]);
  endfunction

  function automatic logic fin_op(input logic [7:0] b);
    return (b[7:4] == 4'h3) && !b[0];
  endfunction

  function automatic logic [7:0] strobes();
    return {X3, X2, X1, M2, M1, A3, A2, A1};
  endfunction

  // One machine cycle carrying byte b; optional X3 stall and optional reset at M1.
  task automatic mcycle(input logic [7:0] b, input int stall_n, input bit rst_mid);
    logic cur_c2, cur_fin, nx_second, nx_fin;
    exp_t e;
    cur_c2  = m_second;
    cur_fin = m_fin;
    if (!m_second) begin
      m_op0     = b;
      nx_second = two_word(b) || fin_op(b);
      nx_fin    = fin_op(b);
    end else begin
      if (!m_fin) m_op1 = b;
      nx_second = 1'b0;
      nx_fin    = 1'b0;
    end
    e.c2 = cur_c2; e.fin = cur_fin; e.op0 = m_op0; e.op1 = m_op1;
    exp_q.push_back(e);

    for (int p = 0; p < 8; p++) begin
      logic [7:0] onehot;
      @(negedge CLK);
      onehot = 8'h01 << p;
      check("strobes", {24'h0, strobes()}, {24'h0, onehot});
      check("sync", {31'h0, SYNC}, {31'h0, (p == 7)});
      check("cycle2", {31'h0, cycle2}, {31'h0, cur_c2});
      check("do_fin", {31'h0, do_fin}, {31'h0, cur_fin});
      if (p == 3)      DATA_I = b[7:4];
      else if (p == 4) DATA_I = b[3:0];
      else             DATA_I = 4'($urandom_range(0, 15));

      if (rst_mid && p == 3) begin
        RES = 1'b1;
        @(negedge CLK);
        check("rst_strobes", {24'h0, strobes()}, 32'h0);
        check("rst_sync", {31'h0, SYNC}, 32'h0);
        check("rst_cycle2", {31'h0, cycle2}, 32'h0);
        check("rst_do_fin", {31'h0, do_fin}, 32'h0);
        check("rst_opropa0", {24'h0, opropa0}, 32'h0);
        check("rst_opropa1", {24'h0, opropa1}, 32'h0);
        RES = 1'b0;
        @(posedge CLK);
        m_second = 1'b0; m_fin = 1'b0; m_op0 = 8'h00; m_op1 = 8'h00;
        exp_q.delete();
        return;
      end

      if (p == 7 && stall_n > 0) begin
        STALL = 1'b1;
        for (int k = 1; k <= stall_n; k++) begin
          @(negedge CLK);
          check("stall_sync", {31'h0, SYNC}, 32'h1);
          check("stall_strobes", {24'h0, strobes()}, 32'h80);
          check("stall_cycle2", {31'h0, cycle2}, {31'h0, cur_c2});
          if (k == stall_n) STALL = 1'b0;
        end
      end
    end
    m_second = nx_second;
    m_fin    = nx_fin;
  endtask

  // Monitor: X1 is where the fetch latch result first becomes visible.
  initial begin
    forever begin
      @(negedge CLK);
      if (X1 === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("x1_unexpected", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("x1_opropa0", {24'h0, opropa0}, {24'h0, e.op0});
          check("x1_opropa1", {24'h0, opropa1}, {24'h0, e.op1});
          check("x1_cycle2", {31'h0, cycle2}, {31'h0, e.c2});
          check("x1_do_fin", {31'h0, do_fin}, {31'h0, e.fin});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sn;
    RES = 1'b1;
    @(posedge CLK);
    repeat (3) begin
      @(negedge CLK);
      check("reset_strobes", {24'h0, strobes()}, 32'h0);
      check("reset_sync", {31'h0, SYNC}, 32'h0);
      check("reset_opropa0", {24'h0, opropa0}, 32'h0);
      check("reset_opropa1", {24'h0, opropa1}, 32'h0);
      check("reset_cycle2", {31'h0, cycle2}, 32'h0);
      check("reset_do_fin", {31'h0, do_fin}, 32'h0);
    end
    RES = 1'b0;
    @(posedge CLK);

    // Directed sequences
    mcycle(8'hD5, 0, 1'b0);   // LDM, single word
    mcycle(8'h24, 0, 1'b0);   // FIM P2
    mcycle(8'hAB, 0, 1'b0);
    mcycle(8'h25, 0, 1'b0);   // SRC, single word
    mcycle(8'h40, 0, 1'b0);   // JUN
    mcycle(8'h2A, 0, 1'b0);   // second word looks like FIM, must not chain
    mcycle(8'hD1, 0, 1'b0);
    mcycle(8'h24, 0, 1'b0);   // load opropa1 = 0x77
    mcycle(8'h77, 0, 1'b0);
    mcycle(8'h32, 0, 1'b0);   // FIN P1
    mcycle(8'h9C, 0, 1'b0);   // data cycle, latches untouched
`ifdef FETCH_STALL_EN
    mcycle(8'hD3, 5, 1'b0);   // SYNC held for 6 cycles
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      sn = 0;
`ifdef FETCH_STALL_EN
      if ($urandom_range(0, 7) == 0) sn = $urandom_range(1, 3);
`endif
      mcycle(8'($urandom_range(0, 255)), sn, 1'b0);
    end

    // Reset during M1 of a FIM second cycle
    if (m_second) mcycle(8'hE0, 0, 1'b0);
    mcycle(8'h24, 0, 1'b0);
    mcycle(8'h5A, 0, 1'b1);
    mcycle(8'hD7, 0, 1'b0);
    mcycle(8'h12, 0, 1'b0);   // JCN
    mcycle(8'h34, 0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
